// File: rtl/axis_shift_arbiter_if.sv
// axis_shift_arbiter_if: bundle of the packed multi-source AXI4-Stream input
// side and the single-stream output side of the shift-datapath arbiter.
//   s_tdata/s_tkeep/s_tstrb/s_tvalid/s_tlast : source beats, source i in slice i
//   s_tready                                  : per-source ready (one-hot or zero)
//   m_tdata/m_tkeep/m_tstrb/m_tvalid/m_tlast  : registered stream to the shift block
//   m_tid                                     : source index carried with each beat
//   m_tready                                  : ready from the shift block
// slave  : arbiter view (consumes sources, drives the shared stream)
// master : environment view (drives sources, sinks the shared stream)
interface axis_shift_arbiter_if #(
    parameter int unsigned BUS_WIDTH  = 512,
    parameter int unsigned KEEP_WIDTH = BUS_WIDTH / 8,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned SRC_W      = 2
);
    logic [NUM_SRC*BUS_WIDTH-1:0]  s_tdata;
    logic [NUM_SRC*KEEP_WIDTH-1:0] s_tkeep;
    logic [NUM_SRC*KEEP_WIDTH-1:0] s_tstrb;
    logic [NUM_SRC-1:0]            s_tvalid;
    logic [NUM_SRC-1:0]            s_tlast;
    logic [NUM_SRC-1:0]            s_tready;
    logic [BUS_WIDTH-1:0]          m_tdata;
    logic [KEEP_WIDTH-1:0]         m_tkeep;
    logic [KEEP_WIDTH-1:0]         m_tstrb;
    logic                          m_tvalid;
    logic                          m_tlast;
    logic [SRC_W-1:0]              m_tid;
    logic                          m_tready;

    modport slave (
        input  s_tdata, s_tkeep, s_tstrb, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tstrb, m_tvalid, m_tlast, m_tid
    );

    modport master (
        output s_tdata, s_tkeep, s_tstrb, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tstrb, m_tvalid, m_tlast, m_tid
    );
endinterface

// File: rtl/axis_shift_arbiter.sv
// axis_shift_arbiter: packet-locked round-robin arbiter sharing one AXI4-Stream
// shift datapath between NUM_SRC (2..4) sources, with one output register stage.
//   aclk   : clock, rising edge
//   ARESET : asynchronous active-high reset
//   axis   : source/sink stream bundle (slave modport)
//   busy   : high while a packet is locked to a source
module axis_shift_arbiter #(
    parameter int unsigned BUS_WIDTH  = 512,
    parameter int unsigned KEEP_WIDTH = BUS_WIDTH / 8,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned SRC_W      = 2
) (
    input  logic                aclk,
    input  logic                ARESET,
    axis_shift_arbiter_if.slave axis,
    output logic                busy
);
    typedef enum logic {ST_IDLE = 1'b0, ST_PASS = 1'b1} state_t;

    state_t                state_q;
    logic [SRC_W-1:0]      grant_q;
    logic [SRC_W-1:0]      rr_ptr_q;
    logic [SRC_W-1:0]      rr_ptr_d;

    logic [SRC_W-1:0]      pick_c;
    logic                  pick_vld_c;
    logic [SRC_W-1:0]      cand_c;
    logic [BUS_WIDTH-1:0]  sel_data_c;
    logic [KEEP_WIDTH-1:0] sel_keep_c;
    logic [KEEP_WIDTH-1:0] sel_strb_c;
    logic                  sel_valid_c;
    logic                  sel_last_c;
    logic                  room_c;
    logic                  accept_c;

    // Round-robin pick: first requester scanning upward from rr_ptr, wrapping.
    always_comb begin
        pick_c     = '0;
        pick_vld_c = 1'b0;
        cand_c     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand_c = SRC_W'((32'(rr_ptr_q) + i) % NUM_SRC);
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
                if (!pick_vld_c && (cand_c == SRC_W'(j)) && axis.s_tvalid[j]) begin
                    pick_vld_c = 1'b1;
                    pick_c     = SRC_W'(j);
                end
            end
        end
    end

    // Granted source's slice of the packed input bus.
    always_comb begin
        sel_data_c  = '0;
        sel_keep_c  = '0;
        sel_strb_c  = '0;
        sel_valid_c = 1'b0;
        sel_last_c  = 1'b0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (grant_q == SRC_W'(j)) begin
                sel_data_c  = axis.s_tdata[j*BUS_WIDTH +: BUS_WIDTH];
                sel_keep_c  = axis.s_tkeep[j*KEEP_WIDTH +: KEEP_WIDTH];
                sel_strb_c  = axis.s_tstrb[j*KEEP_WIDTH +: KEEP_WIDTH];
                sel_valid_c = axis.s_tvalid[j];
                sel_last_c  = axis.s_tlast[j];
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign room_c   = !axis.m_tvalid || axis.m_tready;
    assign accept_c = (state_q == ST_PASS) && sel_valid_c && room_c;
    assign rr_ptr_d = SRC_W'((32'(grant_q) + 32'd1) % NUM_SRC);

    // Only the locked source sees ready; everyone else waits.
    always_comb begin
        axis.s_tready = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            axis.s_tready[j] = (state_q == ST_PASS) && (grant_q == SRC_W'(j)) && room_c;
        end
    end

    // Arbitration FSM plus the output register stage.
    always_ff @(posedge aclk or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            busy          <= 1'b0;
            axis.m_tvalid <= 1'b0;
            axis.m_tlast  <= 1'b0;
            axis.m_tdata  <= '0;
            axis.m_tkeep  <= '0;
            axis.m_tstrb  <= '0;
            axis.m_tid    <= '0;
        end else begin
            if (accept_c) begin
                axis.m_tvalid <= 1'b1;
                axis.m_tlast  <= sel_last_c;
                axis.m_tdata  <= sel_data_c;
                axis.m_tkeep  <= sel_keep_c;
                axis.m_tstrb  <= sel_strb_c;
                axis.m_tid    <= grant_q;
            end else if (axis.m_tready) begin
                axis.m_tvalid <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_c) begin
                        grant_q <= pick_c;
                        state_q <= ST_PASS;
                        busy    <= 1'b1;
                    end
                end
                ST_PASS: begin
                    // Lock holds through bubbles; only the accepted tlast releases it.
                    if (accept_c && sel_last_c) begin
                        state_q  <= ST_IDLE;
                        rr_ptr_q <= rr_ptr_d;
                        busy     <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_shift_arbiter.sv
// tb_axis_shift_arbiter: directed bench for axis_shift_arbiter. Two instances:
// u2 (NUM_SRC=2, 512-bit) and u4 (NUM_SRC=4, 256-bit) sharing clock and reset.
module tb_axis_shift_arbiter;
    localparam int unsigned BUS2 = 512;
    localparam int unsigned K2   = BUS2 / 8;
    localparam int unsigned BUS4 = 256;
    localparam int unsigned K4   = BUS4 / 8;
    localparam int unsigned W    = 512;

    logic aclk = 1'b0;
    logic areset;
    logic busy2;
    logic busy4;

    int    checks = 0;
    int    errors = 0;
    int    step   = 0;
    string tname  = "init";

    logic [K4-1:0] keep_tab [4];
    logic [K4-1:0] strb_tab [4];

    axis_shift_arbiter_if #(.BUS_WIDTH(BUS2), .KEEP_WIDTH(K2), .NUM_SRC(2), .SRC_W(2)) if2 ();
    axis_shift_arbiter_if #(.BUS_WIDTH(BUS4), .KEEP_WIDTH(K4), .NUM_SRC(4), .SRC_W(2)) if4 ();

    axis_shift_arbiter #(.BUS_WIDTH(BUS2), .KEEP_WIDTH(K2), .NUM_SRC(2), .SRC_W(2)) u2 (
        .aclk   (aclk),
        .ARESET (areset),
        .axis   (if2),
        .busy   (busy2)
    );

    axis_shift_arbiter #(.BUS_WIDTH(BUS4), .KEEP_WIDTH(K4), .NUM_SRC(4), .SRC_W(2)) u4 (
        .aclk   (aclk),
        .ARESET (areset),
        .axis   (if4),
        .busy   (busy4)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on u2: drive inputs, check outputs mid-cycle, advance one edge.
    task automatic vec2(input logic v0, input logic [7:0] d0, input logic l0,
                        input logic v1, input logic [7:0] d1, input logic l1,
                        input logic mr,
                        input logic ev, input logic [7:0] ed, input logic [1:0] etid,
                        input logic el, input logic [1:0] esr, input logic eb);
        string p;
        if2.s_tvalid = {v1, v0};
        if2.s_tlast  = {l1, l0};
        if2.s_tdata  = {BUS2'(d1), BUS2'(d0)};
        if2.m_tready = mr;
        #1;
        p = $sformatf("%s.%0d", tname, step);
        chk({p, ".m_tvalid"}, W'(if2.m_tvalid), W'(ev));
        if (ev) begin
            chk({p, ".m_tdata"}, W'(if2.m_tdata), W'(ed));
            chk({p, ".m_tid"},   W'(if2.m_tid),   W'(etid));
            chk({p, ".m_tlast"}, W'(if2.m_tlast), W'(el));
            chk({p, ".m_tkeep"}, W'(if2.m_tkeep), W'({K2{1'b1}}));
        end
        chk({p, ".s_tready"}, W'(if2.s_tready), W'(esr));
        chk({p, ".busy"},     W'(busy2),        W'(eb));
        step++;
        @(posedge aclk);
        #1;
    endtask

    // One cycle on u4: sources carry fixed single-beat packets, only valid varies.
    task automatic vec4(input logic [3:0] vmask, input logic ev, input logic [1:0] etid,
                        input logic [3:0] esr, input logic eb);
        string p;
        if4.s_tvalid = vmask;
        #1;
        p = $sformatf("%s.%0d", tname, step);
        chk({p, ".m_tvalid"}, W'(if4.m_tvalid), W'(ev));
        if (ev) begin
            chk({p, ".m_tdata"}, W'(if4.m_tdata), W'(BUS4'(8'h80) + BUS4'(etid)));
            chk({p, ".m_tid"},   W'(if4.m_tid),   W'(etid));
            chk({p, ".m_tlast"}, W'(if4.m_tlast), W'(1'b1));
            chk({p, ".m_tkeep"}, W'(if4.m_tkeep), W'(keep_tab[etid]));
            chk({p, ".m_tstrb"}, W'(if4.m_tstrb), W'(strb_tab[etid]));
        end
        chk({p, ".s_tready"}, W'(if4.s_tready), W'(esr));
        chk({p, ".busy"},     W'(busy4),        W'(eb));
        step++;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_reset2(input string p);
        chk({p, ".m_tvalid"}, W'(if2.m_tvalid), W'(1'b0));
        chk({p, ".m_tlast"},  W'(if2.m_tlast),  W'(1'b0));
        chk({p, ".m_tdata"},  W'(if2.m_tdata),  W'(0));
        chk({p, ".m_tkeep"},  W'(if2.m_tkeep),  W'(0));
        chk({p, ".m_tstrb"},  W'(if2.m_tstrb),  W'(0));
        chk({p, ".m_tid"},    W'(if2.m_tid),    W'(0));
        chk({p, ".s_tready"}, W'(if2.s_tready), W'(0));
        chk({p, ".busy"},     W'(busy2),        W'(1'b0));
    endtask

    initial begin
        keep_tab[0] = '1;
        keep_tab[1] = 32'h0000_FFFF;
        keep_tab[2] = '0;
        keep_tab[3] = 32'h00FF_00FF;
        strb_tab[0] = '1;
        strb_tab[1] = 32'h0000_0FFF;
        strb_tab[2] = '0;
        strb_tab[3] = 32'h000F_000F;

        areset       = 1'b1;
        if2.s_tvalid = '0;
        if2.s_tlast  = '0;
        if2.s_tdata  = '0;
        if2.s_tkeep  = '1;
        if2.s_tstrb  = '1;
        if2.m_tready = 1'b1;
        if4.s_tvalid = '0;
        if4.s_tlast  = '1;
        if4.m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if4.s_tdata[i*BUS4 +: BUS4] = BUS4'(8'h80 + 8'(i));
            if4.s_tkeep[i*K4 +: K4]     = keep_tab[i];
            if4.s_tstrb[i*K4 +: K4]     = strb_tab[i];
        end

        repeat (2) @(posedge aclk);
        #1;
        chk_reset2("reset.u2");
        chk("reset.u4.m_tvalid", W'(if4.m_tvalid), W'(1'b0));
        chk("reset.u4.s_tready", W'(if4.s_tready), W'(0));
        areset = 1'b0;

        // Single 3-beat packet from source 1.
        tname = "single"; step = 0;
        vec2(0, 8'h00, 0,  1, 8'hA1, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);
        vec2(0, 8'h00, 0,  1, 8'hA1, 0,  1,  0, 8'h00, 2'd0, 0,  2'b10, 1);
        vec2(0, 8'h00, 0,  1, 8'hA2, 0,  1,  1, 8'hA1, 2'd1, 0,  2'b10, 1);
        vec2(0, 8'h00, 0,  1, 8'hA3, 1,  1,  1, 8'hA2, 2'd1, 0,  2'b10, 1);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  1, 8'hA3, 2'd1, 1,  2'b00, 0);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);

        // Both sources stream 2-beat packets; grants alternate 0,1,0,1.
        tname = "fair"; step = 0;
        vec2(1, 8'h10, 0,  1, 8'h20, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);
        vec2(1, 8'h10, 0,  1, 8'h20, 0,  1,  0, 8'h00, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h11, 1,  1, 8'h20, 0,  1,  1, 8'h10, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h12, 0,  1, 8'h20, 0,  1,  1, 8'h11, 2'd0, 1,  2'b00, 0);
        vec2(1, 8'h12, 0,  1, 8'h20, 0,  1,  0, 8'h00, 2'd0, 0,  2'b10, 1);
        vec2(1, 8'h12, 0,  1, 8'h21, 1,  1,  1, 8'h20, 2'd1, 0,  2'b10, 1);
        vec2(1, 8'h12, 0,  1, 8'h22, 0,  1,  1, 8'h21, 2'd1, 1,  2'b00, 0);
        vec2(1, 8'h12, 0,  1, 8'h22, 0,  1,  0, 8'h00, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h13, 1,  1, 8'h22, 0,  1,  1, 8'h12, 2'd0, 0,  2'b01, 1);
        vec2(0, 8'h00, 0,  1, 8'h22, 0,  1,  1, 8'h13, 2'd0, 1,  2'b00, 0);
        vec2(0, 8'h00, 0,  1, 8'h22, 0,  1,  0, 8'h00, 2'd0, 0,  2'b10, 1);
        vec2(0, 8'h00, 0,  1, 8'h23, 1,  1,  1, 8'h22, 2'd1, 0,  2'b10, 1);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  1, 8'h23, 2'd1, 1,  2'b00, 0);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);

        // 4-beat packet from source 0 with m_tready low for 4 cycles.
        tname = "stall"; step = 0;
        vec2(1, 8'h30, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);
        vec2(1, 8'h30, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h31, 0,  0, 8'h00, 0,  0,  1, 8'h30, 2'd0, 0,  2'b00, 1);
        vec2(1, 8'h31, 0,  0, 8'h00, 0,  0,  1, 8'h30, 2'd0, 0,  2'b00, 1);
        vec2(1, 8'h31, 0,  0, 8'h00, 0,  0,  1, 8'h30, 2'd0, 0,  2'b00, 1);
        vec2(1, 8'h31, 0,  0, 8'h00, 0,  0,  1, 8'h30, 2'd0, 0,  2'b00, 1);
        vec2(1, 8'h31, 0,  0, 8'h00, 0,  1,  1, 8'h30, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h32, 0,  0, 8'h00, 0,  1,  1, 8'h31, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h33, 1,  0, 8'h00, 0,  1,  1, 8'h32, 2'd0, 0,  2'b01, 1);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  1, 8'h33, 2'd0, 1,  2'b00, 0);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);

        // Source 0 holds the lock through a 3-cycle bubble while source 1 waits.
        tname = "bubble"; step = 0;
        vec2(1, 8'h40, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);
        vec2(1, 8'h40, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h41, 0,  1, 8'h50, 1,  1,  1, 8'h40, 2'd0, 0,  2'b01, 1);
        vec2(0, 8'h00, 0,  1, 8'h50, 1,  1,  1, 8'h41, 2'd0, 0,  2'b01, 1);
        vec2(0, 8'h00, 0,  1, 8'h50, 1,  1,  0, 8'h00, 2'd0, 0,  2'b01, 1);
        vec2(0, 8'h00, 0,  1, 8'h50, 1,  1,  0, 8'h00, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h42, 1,  1, 8'h50, 1,  1,  0, 8'h00, 2'd0, 0,  2'b01, 1);
        vec2(0, 8'h00, 0,  1, 8'h50, 1,  1,  1, 8'h42, 2'd0, 1,  2'b00, 0);
        vec2(0, 8'h00, 0,  1, 8'h50, 1,  1,  0, 8'h00, 2'd0, 0,  2'b10, 1);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  1, 8'h50, 2'd1, 1,  2'b00, 0);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);

        // Reset asserted after beat 2 of a 5-beat packet; clears without a clock edge.
        tname = "rst_mid"; step = 0;
        vec2(1, 8'h60, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);
        vec2(1, 8'h60, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b01, 1);
        vec2(1, 8'h61, 0,  0, 8'h00, 0,  1,  1, 8'h60, 2'd0, 0,  2'b01, 1);
        if2.s_tdata = {BUS2'(0), BUS2'(8'h62)};
        #1;
        chk("rst_mid.pre.m_tdata",  W'(if2.m_tdata),  W'(8'h61));
        chk("rst_mid.pre.m_tvalid", W'(if2.m_tvalid), W'(1'b1));
        areset = 1'b1;
        #1;
        chk_reset2("rst_mid.async");
        if2.s_tvalid = '0;
        @(posedge aclk);
        #1;
        chk_reset2("rst_mid.held");
        areset = 1'b0;

        tname = "after_rst"; step = 0;
        vec2(0, 8'h00, 0,  1, 8'h70, 1,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);
        vec2(0, 8'h00, 0,  1, 8'h70, 1,  1,  0, 8'h00, 2'd0, 0,  2'b10, 1);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  1, 8'h70, 2'd1, 1,  2'b00, 0);
        vec2(0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 2'd0, 0,  2'b00, 0);

        // Four sources, one single-beat packet each (source 2 is a null beat).
        tname = "quad"; step = 0;
        vec4(4'b1111, 0, 2'd0, 4'b0000, 0);
        vec4(4'b1111, 0, 2'd0, 4'b0001, 1);
        vec4(4'b1110, 1, 2'd0, 4'b0000, 0);
        vec4(4'b1110, 0, 2'd0, 4'b0010, 1);
        vec4(4'b1100, 1, 2'd1, 4'b0000, 0);
        vec4(4'b1100, 0, 2'd0, 4'b0100, 1);
        vec4(4'b1000, 1, 2'd2, 4'b0000, 0);
        vec4(4'b1000, 0, 2'd0, 4'b1000, 1);
        vec4(4'b0000, 1, 2'd3, 4'b0000, 0);
        vec4(4'b0000, 0, 2'd0, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
